// File: rtl/regfile_mp_if.sv
// Port bundle for regfile_mp: write/read ports packed per index into flat vectors,
// plus the ready flag and registered read data coming back from the register file.
interface regfile_mp_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(NREGS);

    logic                ready;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;

    modport master (
        output we, waddr, wdata, raddr,
        input  ready, rdata
    );

    modport slave (
        input  we, waddr, wdata, raddr,
        output ready, rdata
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, optional write-to-read bypass,
// optional hardwired zero register and a post-reset clear sequencer.
module regfile_mp #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q, state_d;
    logic [AW:0]         clr_idx_q, clr_idx_d;
    logic                ready_q, ready_d;
    logic [NRD*XLEN-1:0] rdata_q, rdata_d;
    logic [XLEN-1:0]     mem_q [NREGS];
    logic [XLEN-1:0]     mem_d [NREGS];
    logic [NWR-1:0]      wr_ok;

    // An address is live when it names a real, writable entry.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        for (int i = 0; i < NWR; i++) begin
            wr_ok[i] = bus.we[i] && addr_live(bus.waddr[i*AW +: AW]);
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        mem_d     = mem_q;
        case (state_q)
            CLEAR: begin
                mem_d[clr_idx_q[AW-1:0]] = '0;
                clr_idx_d = clr_idx_q + (AW+1)'(1);
                if (clr_idx_q == (AW+1)'(NREGS - 1)) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                // Ascending order lets the highest-indexed port win a collision.
                for (int i = 0; i < NWR; i++) begin
                    if (wr_ok[i]) begin
                        mem_d[bus.waddr[i*AW +: AW]] = bus.wdata[i*XLEN +: XLEN];
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        if (state_q == RUN) begin
            for (int j = 0; j < NRD; j++) begin
                if (addr_live(bus.raddr[j*AW +: AW])) begin
                    rdata_d[j*XLEN +: XLEN] = mem_q[bus.raddr[j*AW +: AW]];
                    if (BYPASS != 0) begin
                        for (int i = 0; i < NWR; i++) begin
                            if (wr_ok[i] && (bus.waddr[i*AW +: AW] == bus.raddr[j*AW +: AW])) begin
                                rdata_d[j*XLEN +: XLEN] = bus.wdata[i*XLEN +: XLEN];
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
        end
    end

    // Storage is deliberately unreset; the clear sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
endmodule
